// File: rtl/mem_arb_pkg.sv
// Shared types and the rotating-priority search used by the S-array memory arbiter.
// Purely declarative: no state, no clocking.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        ACK     = 3'd4
    } state_t;

    // Upper bound on the client count the search function can handle.
    localparam int MAX_CLIENTS = 32;
    localparam int MAX_IDX_W   = $clog2(MAX_CLIENTS);

    // First set request bit scanning last+1, last+2, ... modulo n; -1 when none.
    // Walking the offsets downward lets the nearest hit overwrite farther ones.
    function automatic int next_grant(input logic [MAX_CLIENTS-1:0] req,
                                      input int                     last,
                                      input int                     n);
        int win;
        int idx;
        win = -1;
        for (int i = MAX_CLIENTS; i >= 1; i--) begin
            if (i <= n) begin
                idx = last + i;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[idx[MAX_IDX_W-1:0]]) begin
                    win = idx;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin winner selection: zero latency.
// No backpressure; winner_o is meaningful only while found_o is high.
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int IDX_W       = $clog2(NUM_CLIENTS)
) (
    input  logic [NUM_CLIENTS-1:0] req_i,
    input  logic [IDX_W-1:0]       last_i,
    output logic                   found_o,
    output logic [IDX_W-1:0]       winner_o
);

    assign found_o  = |req_i;
    assign winner_o = found_o
                    ? IDX_W'(next_grant(MAX_CLIENTS'(req_i), int'(last_i), NUM_CLIENTS))
                    : '0;

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin time-sharing of the single-port S-array RAM; ack at T0+RD_LATENCY+2.
// Requests are held by clients until ack; inputs are sampled only while idle.
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int NUM_CLIENTS = 4,
    parameter  int ADDR_W      = 8,
    parameter  int DATA_W      = 8,
    parameter  int RD_LATENCY  = 2,
    localparam int IDX_W       = $clog2(NUM_CLIENTS)
) (
    input  logic                          sm_clk,
    input  logic                          reset,
    input  logic [NUM_CLIENTS-1:0]        req,
    input  logic [NUM_CLIENTS-1:0]        wren_i,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] addr_i,
    input  logic [NUM_CLIENTS*DATA_W-1:0] wdata_i,
    output logic [NUM_CLIENTS-1:0]        ack,
    output logic [NUM_CLIENTS*DATA_W-1:0] rdata_o,
    output logic                          mem_wren,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [IDX_W-1:0]              grant_idx,
    output logic                          busy
);

    localparam int               CNT_W    = (RD_LATENCY > 2) ? $clog2(RD_LATENCY) : 1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_CLIENTS - 1);

    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                grant_q, grant_d;
    logic [IDX_W-1:0]                last_q, last_d;
    logic [ADDR_W-1:0]               addr_q, addr_d;
    logic [DATA_W-1:0]               wdata_q, wdata_d;
    logic                            wren_q, wren_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [NUM_CLIENTS*DATA_W-1:0]   rdata_q, rdata_d;
    logic                            found;
    logic [IDX_W-1:0]                winner;

    rr_picker #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .req_i    (req),
        .last_i   (last_q),
        .found_o  (found),
        .winner_o (winner)
    );

    always_ff @(posedge sm_clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
            addr_q  <= '0;
            wdata_q <= '0;
            wren_q  <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wren_q  <= wren_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wren_d   = wren_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        mem_wren = 1'b0;
        ack      = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = winner;
                    last_d  = winner;
                    addr_d  = addr_i[winner*ADDR_W +: ADDR_W];
                    wdata_d = wdata_i[winner*DATA_W +: DATA_W];
                    wren_d  = wren_i[winner];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mem_wren = wren_q;
                if (RD_LATENCY > 1) begin
                    // WAIT lasts RD_LATENCY-1 cycles: counts down to zero inclusive.
                    cnt_d   = CNT_W'(RD_LATENCY - 2);
                    state_d = WAIT;
                end else begin
                    state_d = CAPTURE;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CAPTURE: begin
                if (!wren_q) begin
                    rdata_d[grant_q*DATA_W +: DATA_W] = mem_rdata;
                end
                state_d = ACK;
            end
            ACK: begin
                ack[grant_q] = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign grant_idx = grant_q;
    assign rdata_o   = rdata_q;
    assign busy      = (state_q != IDLE);

endmodule
